// File: rtl/sm_debug_dump_pkg.sv
// sm_debug_dump_pkg
//   Shared constants and types for the schoolMIPS debug dump block.
//   - HDR_BYTE       : first byte of every dump stream
//   - WORD_CNT       : number of 32-bit words sent (32 registers + 32 RAM words)
//   - BYTES_PER_WORD : bytes per word on the wire, MSB first
//   - state_t        : dump sequencer states
//   - byte_sel()     : picks byte bc of a word, counting from the MSB
package sm_debug_dump_pkg;

  localparam logic [7:0] HDR_BYTE       = 8'hA5;
  localparam int         WORD_CNT       = 64;
  localparam int         BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_SEND  = 3'd4,
    ST_FLUSH = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

  // Byte 0 is the most significant byte of the word.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] bc);
    logic [7:0] b;
    case (bc)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sm_debug_dump_uart_tx.sv
// sm_uart_tx
//   UART 8N1 transmitter with a valid/ready byte handshake.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     data[7:0]    : byte to send, taken when valid & ready
//     valid        : byte on data is available
//     ready        : transmitter idle, or in the last cycle of a stop bit
//     tx           : serial line, idle high
//     idle         : no frame in progress
//   A byte accepted in the last stop-bit cycle starts its frame on the very
//   next cycle, so consecutive frames leave no gap on the line.
module sm_uart_tx #(
  parameter int BAUD_DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       idle
);

  logic [9:0]  sh_r;      // {stop, data[7:0], start}; bit 0 is on the line
  logic [15:0] cnt_r;     // cycles left in the current bit, minus one
  logic [3:0]  bitn_r;    // bit position within the frame, 0..9
  logic        active_r;

  logic last_stop_s;
  assign last_stop_s = active_r && (cnt_r == 16'd0) && (bitn_r == 4'd9);
  assign ready       = !active_r || last_stop_s;
  assign idle        = !active_r;
  assign tx          = sh_r[0];

  // Frame sequencer: load on accept, shift one bit per baud period.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_r     <= 10'h3FF;
      cnt_r    <= 16'd0;
      bitn_r   <= 4'd0;
      active_r <= 1'b0;
    end else if (valid && ready) begin
      sh_r     <= {1'b1, data, 1'b0};
      cnt_r    <= 16'(BAUD_DIV - 1);
      bitn_r   <= 4'd0;
      active_r <= 1'b1;
    end else if (active_r) begin
      if (cnt_r == 16'd0) begin
        if (bitn_r == 4'd9) begin
          // Stop bit finished; line already rests at 1 from shifted-in ones.
          active_r <= 1'b0;
        end else begin
          sh_r   <= {1'b1, sh_r[9:1]};
          bitn_r <= bitn_r + 4'd1;
          cnt_r  <= 16'(BAUD_DIV - 1);
        end
      end else begin
        cnt_r <= cnt_r - 16'd1;
      end
    end else begin
      sh_r <= 10'h3FF;
    end
  end

endmodule

// File: rtl/sm_debug_dump.sv
// sm_debug_dump
//   Walks the schoolMIPS debug ports (register file, then data RAM) on a
//   start pulse and streams A5 followed by 64 big-endian words over UART 8N1.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     start             : begin a dump (sampled only while idle)
//     regAddr/regData   : debug register port (address 0 returns PC)
//     ramAddrB/ramDataB : debug RAM port (combinational or 1-cycle read)
//     tx                : UART line, idle high
//     busy              : dump in progress
//     done              : one-cycle pulse when the last stop bit has finished
module sm_debug_dump
  import sm_debug_dump_pkg::*;
#(
  parameter int BAUD_DIV = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [4:0]  ramAddrB,
  input  logic [31:0] ramDataB,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  state_t      state_r;
  logic [6:0]  idx_r;
  logic [1:0]  bc_r;
  logic [31:0] word_r;
  logic        busy_r;
  logic        done_r;

  logic        valid_s;
  logic        ready_s;
  logic        uart_idle_s;
  logic [7:0]  byte_s;
  logic [31:0] sel_data_s;
  logic [6:0]  idx_next_s;

  // Both debug addresses come straight from the word index register.
  assign regAddr    = idx_r[4:0];
  assign ramAddrB   = idx_r[4:0];
  assign busy       = busy_r;
  assign done       = done_r;
  assign sel_data_s = (idx_r < 7'd32) ? regData : ramDataB;
  assign idx_next_s = idx_r + 7'd1;

  // Byte offered to the UART: header in HDR, current word byte in SEND.
  always_comb begin
    valid_s = 1'b0;
    byte_s  = HDR_BYTE;
    case (state_r)
      ST_HDR: begin
        valid_s = 1'b1;
        byte_s  = HDR_BYTE;
      end
      ST_SEND: begin
        valid_s = 1'b1;
        byte_s  = byte_sel(word_r, bc_r);
      end
      default: begin
        valid_s = 1'b0;
        byte_s  = HDR_BYTE;
      end
    endcase
  end

  // Dump sequencer. WAIT gives the new address a full cycle so a registered
  // RAM read is ready by CAPT; this all overlaps the previous frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= 7'd0;
      bc_r    <= 2'd0;
      word_r  <= 32'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            idx_r   <= 7'd0;
            busy_r  <= 1'b1;
            state_r <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (ready_s) begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          state_r <= ST_CAPT;
        end
        ST_CAPT: begin
          word_r  <= sel_data_s;
          bc_r    <= 2'd0;
          state_r <= ST_SEND;
        end
        ST_SEND: begin
          if (ready_s) begin
            if (bc_r != 2'(BYTES_PER_WORD - 1)) begin
              bc_r <= bc_r + 2'd1;
            end else begin
              idx_r <= idx_next_s;
              if (idx_next_s == 7'(WORD_CNT)) begin
                state_r <= ST_FLUSH;
              end else begin
                state_r <= ST_WAIT;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (uart_idle_s) begin
            done_r  <= 1'b1;
            state_r <= ST_FIN;
          end
        end
        ST_FIN: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  sm_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk   (clk),
    .rst   (rst),
    .data  (byte_s),
    .valid (valid_s),
    .ready (ready_s),
    .tx    (tx),
    .idle  (uart_idle_s)
  );

endmodule
